// File: rtl/rd_fram_pkg.sv
// Shared sizing helpers for the ping-pong line buffer: lane ratio, read index
// width and the bit offset of a read lane inside a write word.
package rd_fram_pkg;

    localparam int WR_DW_DEF = 256;
    localparam int RD_DW_DEF = 32;
    localparam int WR_AW_DEF = 9;

    function automatic int calc_ratio(input int wr_dw, input int rd_dw);
        return wr_dw / rd_dw;
    endfunction

    function automatic int calc_rd_idx_w(input int wr_aw, input int ratio);
        return wr_aw + $clog2(ratio);
    endfunction

    localparam int RATIO    = calc_ratio(WR_DW_DEF, RD_DW_DEF);
    localparam int RD_IDX_W = calc_rd_idx_w(WR_AW_DEF, RATIO);

    // lane 0 sits in the least significant bits, lanes ascend
    function automatic int lane_lsb(input int lane, input int rd_dw);
        return lane * rd_dw;
    endfunction

endpackage

// File: rtl/sdp_ram_2clk.sv
// Simple dual-port RAM, independent write/read clocks, one-cycle registered read.
module sdp_ram_2clk #(
    parameter int DW = 256,
    parameter int AW = 10
) (
    input  logic          wclk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          rclk,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rq
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];

    // write port
    always_ff @(posedge wclk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // read port, holds its last word while idle
    always_ff @(posedge rclk) begin
        if (re) begin
            rq <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/rd_fram_pingpong.sv
// Two-bank line buffer: wide words written in wr_clk domain, narrow lanes read
// in rd_clk domain; bank full/free handshakes cross as toggle flags.
module rd_fram_pingpong
    import rd_fram_pkg::*;
#(
    parameter int WR_DW      = 256,
    parameter int RD_DW      = 32,
    parameter int LINE_WORDS = 480,
    parameter int WR_AW      = 9
) (
    input  logic             wr_clk,
    input  logic             tb_wr_rst,
    input  logic             rd_clk,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WR_DW-1:0] wr_data,
    output logic             wr_ovf,
    input  logic             rd_en,
    output logic             line_rdy,
    output logic [RD_DW-1:0] rd_data,
    output logic             rd_valid,
    output logic             rd_line_done,
    output logic             rd_udf
);

    localparam int N_LANE = calc_ratio(WR_DW, RD_DW);
    localparam int LOG2R  = $clog2(N_LANE);
    localparam int IDX_W  = calc_rd_idx_w(WR_AW, N_LANE);
    localparam int LANE_W = (LOG2R > 0) ? LOG2R : 1;
    localparam logic [WR_AW-1:0] WR_LAST = WR_AW'(LINE_WORDS - 1);
    localparam logic [IDX_W-1:0] RD_LAST = IDX_W'(LINE_WORDS * N_LANE - 1);

    // write domain
    logic [WR_AW-1:0] wr_cnt_r;
    logic             wr_bank_r;
    logic             wr_ovf_r;
    logic [1:0]       full_tgl_r;
    logic [1:0]       free_s1_r;
    logic [1:0]       free_s2_r;
    logic [1:0]       wr_full_s;
    logic             wr_acc_s;
    logic             wr_last_s;

    // read domain
    logic [1:0]       rst_sh_r;
    logic             rd_rst_s;
    logic [1:0]       full_s1_r;
    logic [1:0]       full_s2_r;
    logic [1:0]       free_tgl_r;
    logic [1:0]       rd_full_s;
    logic             rd_bank_r;
    logic [IDX_W-1:0] rd_idx_r;
    logic [LANE_W-1:0] lane_r;
    logic [LANE_W-1:0] lane_s;
    logic [WR_AW-1:0] rd_word_s;
    logic             rd_acc_s;
    logic             rd_last_s;
    logic             rd_valid_r;
    logic             done_r;
    logic             udf_r;
    logic [WR_DW-1:0] ram_q_s;

    // a bank is full while its full toggle differs from the returned free toggle
    assign wr_full_s = full_tgl_r ^ free_s2_r;
    assign wr_ready  = ~wr_full_s[wr_bank_r];
    assign wr_acc_s  = wr_valid & wr_ready;
    assign wr_last_s = (wr_cnt_r == WR_LAST);
    assign wr_ovf    = wr_ovf_r;

    // write counter, bank pointer, full toggles and free-toggle synchroniser
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            wr_cnt_r   <= {WR_AW{1'b0}};
            wr_bank_r  <= 1'b0;
            wr_ovf_r   <= 1'b0;
            full_tgl_r <= 2'b00;
            free_s1_r  <= 2'b00;
            free_s2_r  <= 2'b00;
        end else begin
            free_s1_r <= free_tgl_r;
            free_s2_r <= free_s1_r;
            if (wr_valid && !wr_ready) begin
                wr_ovf_r <= 1'b1;
            end
            if (wr_acc_s) begin
                if (wr_last_s) begin
                    wr_cnt_r              <= {WR_AW{1'b0}};
                    wr_bank_r             <= ~wr_bank_r;
                    full_tgl_r[wr_bank_r] <= ~full_tgl_r[wr_bank_r];
                end else begin
                    wr_cnt_r <= wr_cnt_r + WR_AW'(1);
                end
            end
        end
    end

    // read-domain reset: asserts with tb_wr_rst, releases after two rd_clk edges
    always_ff @(posedge rd_clk or posedge tb_wr_rst) begin
        if (tb_wr_rst) begin
            rst_sh_r <= 2'b11;
        end else begin
            rst_sh_r <= {rst_sh_r[0], 1'b0};
        end
    end
    assign rd_rst_s = rst_sh_r[1];

    assign rd_full_s = full_s2_r ^ free_tgl_r;
    assign line_rdy  = rd_full_s[rd_bank_r];
    assign rd_acc_s  = rd_en & line_rdy;
    assign rd_last_s = (rd_idx_r == RD_LAST);
    assign rd_word_s = WR_AW'(rd_idx_r >> LOG2R);
    assign lane_s    = (LOG2R > 0) ? LANE_W'(rd_idx_r) : {LANE_W{1'b0}};

    // read index, bank pointer, free toggles and full-toggle synchroniser
    always_ff @(posedge rd_clk or posedge rd_rst_s) begin
        if (rd_rst_s) begin
            full_s1_r  <= 2'b00;
            full_s2_r  <= 2'b00;
            free_tgl_r <= 2'b00;
            rd_bank_r  <= 1'b0;
            rd_idx_r   <= {IDX_W{1'b0}};
            lane_r     <= {LANE_W{1'b0}};
            rd_valid_r <= 1'b0;
            done_r     <= 1'b0;
            udf_r      <= 1'b0;
        end else begin
            full_s1_r  <= full_tgl_r;
            full_s2_r  <= full_s1_r;
            rd_valid_r <= rd_acc_s;
            done_r     <= rd_acc_s & rd_last_s;
            if (rd_en && !line_rdy) begin
                udf_r <= 1'b1;
            end
            if (rd_acc_s) begin
                lane_r <= lane_s;
                if (rd_last_s) begin
                    rd_idx_r              <= {IDX_W{1'b0}};
                    rd_bank_r             <= ~rd_bank_r;
                    free_tgl_r[rd_bank_r] <= ~free_tgl_r[rd_bank_r];
                end else begin
                    rd_idx_r <= rd_idx_r + IDX_W'(1);
                end
            end
        end
    end

    sdp_ram_2clk #(
        .DW (WR_DW),
        .AW (WR_AW + 1)
    ) u_ram (
        .wclk  (wr_clk),
        .we    (wr_acc_s),
        .waddr ({wr_bank_r, wr_cnt_r}),
        .wdata (wr_data),
        .rclk  (rd_clk),
        .re    (rd_acc_s),
        .raddr ({rd_bank_r, rd_word_s}),
        .rq    (ram_q_s)
    );

    // RAM read register supplies the one-cycle latency; the lane mux follows it
    assign rd_data      = rd_valid_r ? ram_q_s[lane_lsb(int'(lane_r), RD_DW) +: RD_DW]
                                     : {RD_DW{1'b0}};
    assign rd_valid     = rd_valid_r;
    assign rd_line_done = done_r;
    assign rd_udf       = udf_r;

endmodule

// File: tb/tb_rd_fram_pingpong.sv
// Directed bench for rd_fram_pingpong: vector table for the first line, then
// hand-written sequences for overflow, underflow, streaming and mid-line reset.
`timescale 1ns/100ps
module tb_rd_fram_pingpong;

    localparam int WR_DW = 256;
    localparam int RD_DW = 32;
    localparam int LINE_WORDS = 4;
    localparam int WR_AW = 2;
    localparam int NRD = 32;
    localparam int NLINES = 50;

    logic             wr_clk = 1'b0;
    logic             rd_clk = 1'b0;
    logic             tb_wr_rst = 1'b1;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [WR_DW-1:0] wr_data = '0;
    logic             wr_ovf;
    logic             rd_en = 1'b0;
    logic             line_rdy;
    logic [RD_DW-1:0] rd_data;
    logic             rd_valid;
    logic             rd_line_done;
    logic             rd_udf;

    always #5 wr_clk = ~wr_clk;
    always #3.5 rd_clk = ~rd_clk;

    rd_fram_pingpong #(
        .WR_DW(WR_DW), .RD_DW(RD_DW), .LINE_WORDS(LINE_WORDS), .WR_AW(WR_AW)
    ) dut (
        .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .rd_clk(rd_clk),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_ovf(wr_ovf),
        .rd_en(rd_en), .line_rdy(line_rdy), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_line_done(rd_line_done), .rd_udf(rd_udf)
    );

    typedef struct {
        logic        rd_en;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic        exp_done;
    } vec_t;

    vec_t             tbl [34];
    logic [WR_DW-1:0] wq [NLINES*LINE_WORDS];
    int               n_vec = 0;
    int               n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WR_DW-1:0] mkword(input int line, input int w);
        logic [WR_DW-1:0] r;
        for (int l = 0; l < 8; l++) r[l*32 +: 32] = {8'(line), 8'(w), 8'h5A, 8'(l)};
        return r;
    endfunction

    // expected read k of a line: word k/8, lane k%8
    function automatic logic [31:0] mklane(input int line, input int k);
        return {8'(line), 8'(k / 8), 8'h5A, 8'(k % 8)};
    endfunction

    task automatic do_reset();
        wr_valid = 1'b0;
        rd_en = 1'b0;
        tb_wr_rst = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1 tb_wr_rst = 1'b0;
        repeat (4) @(posedge rd_clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_ready"}, 64'(wr_ready), 64'(1));
        chk({tag, "_wr_ovf"}, 64'(wr_ovf), 64'(0));
        chk({tag, "_line_rdy"}, 64'(line_rdy), 64'(0));
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'(0));
        chk({tag, "_rd_line_done"}, 64'(rd_line_done), 64'(0));
        chk({tag, "_rd_udf"}, 64'(rd_udf), 64'(0));
        chk({tag, "_rd_data"}, 64'(rd_data), 64'(0));
    endtask

    task automatic put_word(input logic [WR_DW-1:0] d);
        int b = 0;
        while (!wr_ready && b < 60) begin
            @(posedge wr_clk);
            #1 b++;
        end
        if (!wr_ready) chk("wr_ready_timeout", 64'(wr_ready), 64'(1));
        wr_valid = 1'b1;
        wr_data = d;
        @(posedge wr_clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic wait_rdy(input string name, input int budget);
        int c = 0;
        while (!line_rdy && c < budget) begin
            @(posedge rd_clk);
            #1 c++;
        end
        chk(name, 64'(line_rdy), 64'(1));
    endtask

    task automatic read_line(input int line);
        wait_rdy("line_rdy_wait", 20);
        rd_en = 1'b1;
        for (int k = 0; k < NRD; k++) begin
            @(posedge rd_clk);
            #1;
            if (k == NRD - 1) rd_en = 1'b0;
            chk("rl_valid", 64'(rd_valid), 64'(1));
            chk("rl_data", 64'(rd_data), 64'(mklane(line, k)));
            chk("rl_done", 64'(rd_line_done), 64'(k == NRD - 1));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int j = 0;
        // line 1 vectors: 32 reads with two idle slots
        for (int k = 0; k < NRD; k++) begin
            if (k == 1 || k == 16) begin
                tbl[j] = '{1'b0, 1'b0, 32'h0, 1'b0};
                j++;
            end
            tbl[j] = '{1'b1, 1'b1,
                       (k % 8 == 0) ? 32'hFFFF_FFFF - 32'(k / 8) : 32'hFFFF_FFFF,
                       (k == NRD - 1)};
            j++;
        end

        do_reset();
        chk_reset("rst0");

        // descending counter from all-ones into bank 0
        for (int w = 0; w < LINE_WORDS; w++) put_word({WR_DW{1'b1}} - WR_DW'(w));
        wait_rdy("line_rdy_3clk", 3);
        for (int i = 0; i < 34; i++) begin
            rd_en = tbl[i].rd_en;
            @(posedge rd_clk);
            #1;
            chk("tbl_valid", 64'(rd_valid), 64'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) chk("tbl_data", 64'(rd_data), 64'(tbl[i].exp_data));
            chk("tbl_done", 64'(rd_line_done), 64'(tbl[i].exp_done));
        end
        rd_en = 1'b0;
        chk("line1_drained", 64'(line_rdy), 64'(0));

        // overflow: eight words fill both banks, ninth is dropped
        for (int w = 0; w < 8; w++) put_word(mkword(2 + w / 4, w % 4));
        chk("ovf_wr_ready_low", 64'(wr_ready), 64'(0));
        wr_valid = 1'b1;
        wr_data = mkword(9, 0);
        @(posedge wr_clk);
        #1 wr_valid = 1'b0;
        chk("ovf_sticky", 64'(wr_ovf), 64'(1));
        chk("ovf_still_stalled", 64'(wr_ready), 64'(0));
        read_line(2);
        read_line(3);
        chk("ovf_no_extra_line", 64'(line_rdy), 64'(0));

        // underflow: rd_en with nothing buffered
        rd_en = 1'b1;
        repeat (8) begin
            @(posedge rd_clk);
            #1 chk("udf_no_valid", 64'(rd_valid), 64'(0));
        end
        rd_en = 1'b0;
        chk("udf_sticky", 64'(rd_udf), 64'(1));
        for (int w = 0; w < LINE_WORDS; w++) put_word(mkword(4, w));
        read_line(4);

        // streaming: concurrent writer and reader over 50 lines
        do_reset();
        chk_reset("rst1");
        fork
            begin
                logic [WR_DW-1:0] w;
                for (int i = 0; i < NLINES * LINE_WORDS; i++) begin
                    for (int l = 0; l < 8; l++) w[l*32 +: 32] = $urandom;
                    wq[i] = w;
                    put_word(w);
                end
            end
            begin
                int rc = 0;
                int cyc = 0;
                logic [WR_DW-1:0] tw;
                rd_en = 1'b1;
                while (rc < NLINES * NRD && cyc < 8000) begin
                    @(posedge rd_clk);
                    #1 cyc++;
                    if (rc == NLINES * NRD - 1 && rd_valid === 1'b0) rd_en = 1'b1;
                    if (rd_valid) begin
                        tw = wq[rc / 8];
                        chk("stream_data", 64'(rd_data), 64'(tw[(rc % 8)*32 +: 32]));
                        chk("stream_done", 64'(rd_line_done), 64'(rc % NRD == NRD - 1));
                        rc++;
                    end
                end
                rd_en = 1'b0;
                chk("stream_count", 64'(rc), 64'(NLINES * NRD));
            end
        join
        chk("stream_no_ovf", 64'(wr_ovf), 64'(0));

        // mid-line reset: move both pointers to bank 1, then abort a line
        for (int w = 0; w < LINE_WORDS; w++) put_word(mkword(5, w));
        read_line(5);
        put_word(mkword(6, 0));
        put_word(mkword(6, 1));
        do_reset();
        chk_reset("rst2");
        for (int w = 0; w < LINE_WORDS; w++) put_word(mkword(7, w));
        read_line(7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
